// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, 16x oversampling, mid-bit sampling.
// Define PARITY_EN to add an even-parity bit (11-bit frame) that drives PE.
module uart_receiver #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DIV      = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       RxD,
    output logic [7:0] dout,
    output logic       valid,
    output logic       FE,
    output logic       PE,
    output logic       busy
);

    localparam int unsigned      TickW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    state_e           r_state, w_state_d;
    logic             r_rx_meta, r_rx_s;
    logic [TickW-1:0] r_tick_cnt, w_tick_cnt_d;
    logic [3:0]       r_sample_cnt, w_sample_cnt_d;
    logic [2:0]       r_bit_idx, w_bit_idx_d;
    logic [7:0]       r_shift, w_shift_d;
    logic [7:0]       r_dout, w_dout_d;
    logic             r_valid, w_valid_d;
    logic             r_fe, w_fe_d;
    logic             w_tick;
    logic             w_bit_end;
`ifdef PARITY_EN
    logic             r_par_err, w_par_err_d;
    logic             r_pe, w_pe_d;
`endif

    assign w_tick    = (r_tick_cnt == TickMax);
    assign w_bit_end = w_tick && (r_sample_cnt == 4'd15);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_tick_cnt   <= '0;
            r_sample_cnt <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_fe         <= 1'b0;
`ifdef PARITY_EN
            r_par_err    <= 1'b0;
            r_pe         <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_tick_cnt   <= w_tick_cnt_d;
            r_sample_cnt <= w_sample_cnt_d;
            r_bit_idx    <= w_bit_idx_d;
            r_shift      <= w_shift_d;
            r_dout       <= w_dout_d;
            r_valid      <= w_valid_d;
            r_fe         <= w_fe_d;
`ifdef PARITY_EN
            r_par_err    <= w_par_err_d;
            r_pe         <= w_pe_d;
`endif
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_tick_cnt_d   = w_tick ? '0 : r_tick_cnt + 1'b1;
        w_sample_cnt_d = w_tick ? r_sample_cnt + 1'b1 : r_sample_cnt;
        w_bit_idx_d    = r_bit_idx;
        w_shift_d      = r_shift;
        w_dout_d       = r_dout;
        w_valid_d      = 1'b0;
        w_fe_d         = 1'b0;
`ifdef PARITY_EN
        w_par_err_d    = r_par_err;
        w_pe_d         = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                // Restart the tick phase on the start edge so samples land mid-bit.
                if (!r_rx_s) begin
                    w_state_d      = StStart;
                    w_tick_cnt_d   = '0;
                    w_sample_cnt_d = '0;
                end
            end
            StStart: begin
                if (w_tick && (r_sample_cnt == 4'd7)) begin
                    if (!r_rx_s) begin
                        w_state_d      = StData;
                        w_sample_cnt_d = '0;
                        w_bit_idx_d    = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_shift_d[r_bit_idx] = r_rx_s;
                    w_sample_cnt_d       = '0;
                    w_bit_idx_d          = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef PARITY_EN
                        w_state_d = StParity;
`else
                        w_state_d = StStop;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            StParity: begin
                if (w_bit_end) begin
                    w_par_err_d    = ^{r_shift, r_rx_s};
                    w_sample_cnt_d = '0;
                    w_state_d      = StStop;
                end
            end
`endif
            StStop: begin
                // Leave at mid-stop-bit so a directly following start edge is caught.
                if (w_bit_end) begin
                    w_sample_cnt_d = '0;
`ifdef PARITY_EN
                    w_pe_d         = r_par_err;
`endif
                    if (r_rx_s) begin
                        w_dout_d  = r_shift;
                        w_valid_d = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_fe_d    = 1'b1;
                        w_state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (r_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign FE    = r_fe;
    assign busy  = (r_state != StIdle);
`ifdef PARITY_EN
    assign PE    = r_pe;
`else
    assign PE    = 1'b0;
`endif

endmodule
